i2c_byte_engine: RTL and testbench
==================================

# i2c_byte_engine

Data-phase stage of the I2C master, directly downstream of the START/hold sequencing. Once SCL is low after a START or repeated START, it shifts one byte MSB-first onto the bus, or reads one in, then runs the 9th (ACK) bit. It raises `done` so the master FSM can choose the next byte, a repeated START or a STOP. SCL timing uses the same double-rate divisor register as the START/STOP phases.

## Interface
- `DVSR_W`, default 16: width of the divisor and the phase counter.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `dbl_clock_divisor`  in  DVSR_W  phase length minus one (D); each SCL half-period is D+1 clocks.
- `start`  in  1  request one byte transfer; sampled only while `ready`=1.
- `cmd_read`  in  1  1 = read byte from slave, 0 = write; captured on accept.
- `din`  in  8  write data; captured on accept.
- `ack_in`  in  1  bit the master drives in the ACK slot on reads (0 = ACK, 1 = NACK); captured on accept.
- `sda_in`  in  1  synchronised bus SDA.
- `ready`  out  1  engine idle, can accept `start`.
- `done`  out  1  one-cycle pulse at byte completion.
- `dout`  out  8  received byte; updated only in the `done` cycle.
- `ack_out`  out  1  SDA sampled in the ACK slot; updated only in the `done` cycle.
- `sda_out`  out  1  SDA drive (1 = release).
- `scl_out`  out  1  SCL drive (1 = release).
- `scl_in`  in  1  bus SCL; present only with `I2C_CLOCK_STRETCH_EN`.

## Operation
- States (4-bit encoding): IDLE, DATA_LO, DATA_HI, ACK_LO, ACK_HI.
- Internal registers:
  - `ctr` (DVSR_W bits), `bit_cnt` (3 bits), `shreg` (8 bits).
  - Captured `rd` and `ack` bits.
- **IDLE:** `ready`=1. On `start`, capture `cmd_read`, `din` and `ack_in`, clear `ctr` and `bit_cnt`, then go to DATA_LO.
- **DATA_LO:**
  - `scl_out`=0.
  - `sda_out` = `shreg[7]` on a write, 1 on a read.
  - `ctr` increments each cycle. When `ctr`==D, clear `ctr` and go to DATA_HI.
- **DATA_HI:**
  - `scl_out`=1 and `sda_out` is held.
  - When `ctr`==D, shift `shreg` left; on a read, `sda_in` enters at the LSB.
  - If `bit_cnt`==7, go to ACK_LO; otherwise increment `bit_cnt` and go to DATA_LO.
- **ACK_LO:**
  - `scl_out`=0.
  - `sda_out` = `ack` on a read, 1 on a write.
  - When `ctr`==D, go to ACK_HI.
- **ACK_HI:**
  - `scl_out`=1.
  - When `ctr`==D, latch `ack_out` = `sda_in`, load `dout` (read: `shreg`; write: unchanged), pulse `done` and go to IDLE.
- **Between bytes (IDLE after a transfer):**
  - `scl_out`=0 (bus held low).
  - `sda_out` keeps the last driven value.
- **Comparisons and wrap:** all comparisons are unsigned and full-width. `ctr` never wraps, because it is cleared at D.
- **Changes to `dbl_clock_divisor` mid-byte:** they take effect at the next comparison. The master only changes it while `ready`=1.

## Timing
- **Reset values:** IDLE, `ready`=1, `done`=0, `dout`=8'h00, `ack_out`=1, `sda_out`=1, `scl_out`=1, all counters 0.
- **Latency:** `start` accepted at edge 0. DATA_LO begins at edge 1. `done` is high during cycle 18·(D+1)+1 and `ready` returns in the same cycle.
- **Start while busy:** `start` while `ready`=0 is ignored, with no queuing.
- **Back-to-back bytes:** `start` in the `done`/`ready` cycle is accepted. The next DATA_LO follows immediately with no extra SCL-low cycle.
- **D=0:** every phase lasts 1 clock; a byte takes 18 clocks.
- **Reset mid-byte:** all outputs return to reset values asynchronously and no `done` is produced.

## Configuration
- `I2C_CLOCK_STRETCH_EN` defined:
  - `scl_in` port exists.
  - In DATA_HI and ACK_HI, `ctr` holds while `scl_in`==0, so a slave can stretch the clock.
  - Latency is 18·(D+1)+1 plus the stretched cycles.
- Undefined: no `scl_in` port, and timing is exactly as above.

## Structure
- Shared include `include/i2c.vh` holds the engine state encodings (4-bit, alongside the existing master states) and the ACK/NACK constants (ACK=1'b0, NACK=1'b1).
- One sub-module is natural: `i2c_phase_timer`, i.e. the `ctr` register, the `ctr`==D compare producing `phase_end`, the clear input and the stretch hold input.

## Test plan
- **Write with ACK:** D=3, write `din`=8'hA5, slave pulls `sda_in`=0 in ACK_HI.
  - SDA bits 1,0,1,0,0,1,0,1 change only while SCL is low.
  - `done` in cycle 73; `ack_out`=0; `dout` stays 8'h00.
- **Read with NACK:** D=3, `sda_in` presents 8'h3C, `ack_in`=1.
  - `dout`=8'h3C at `done`.
  - `sda_out`=1 through all 9 bits; `ack_out` reflects the sampled `sda_in`.
- **Busy and back-to-back:** D=0.
  - `start` pulsed at clock 5 is ignored.
  - Second `start` in the `done` cycle gives a second `done` exactly 19 clocks later.
- **Reset mid-byte:** assert `reset` in DATA_HI of bit 4.
  - Immediately `sda_out`=1, `scl_out`=1, `ready`=1.
  - No `done` pulse; `dout`=8'h00.
- **Clock stretch** (`I2C_CLOCK_STRETCH_EN`): D=3, hold `scl_in`=0 for 10 clocks in the first DATA_HI.
  - `done` in cycle 83; data unchanged.

Source files
------------

// File: rtl/i2c_byte_engine_pkg.sv
// Shared encodings for the I2C byte engine: 4-bit engine states and ACK/NACK bus levels.
package i2c_byte_engine_pkg;

   typedef enum logic [3:0] {
      ENG_IDLE    = 4'd0,
      ENG_DATA_LO = 4'd1,
      ENG_DATA_HI = 4'd2,
      ENG_ACK_LO  = 4'd3,
      ENG_ACK_HI  = 4'd4
   } eng_state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_phase_timer.sv
// SCL phase timer: counts clocks within one SCL half-period, flags the last one (ctr == D).
module i2c_phase_timer #(
   parameter int DVSR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic              clr,
   input  logic              hold,
   output logic              phase_end
);

   logic [DVSR_W-1:0] ctr;

   // A held counter never ends its phase, so a stretched SCL high simply extends it.
   assign phase_end = (ctr == dvsr) && !hold;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      ctr <= '0;
      else if (clr)   ctr <= '0;
      else if (!hold) ctr <= ctr + 1'b1;
   end

endmodule

// File: rtl/i2c_byte_engine.sv
// I2C master data phase: shifts one byte MSB-first (write or read) plus the ACK bit.
// Optional feature: I2C_CLOCK_STRETCH_EN adds scl_in and holds SCL-high phases while it is low.
module i2c_byte_engine
   import i2c_byte_engine_pkg::*;
#(
   parameter int DVSR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DVSR_W-1:0] dbl_clock_divisor,
   input  logic              start,
   input  logic              cmd_read,
   input  logic [7:0]        din,
   input  logic              ack_in,
   input  logic              sda_in,
`ifdef I2C_CLOCK_STRETCH_EN
   input  logic              scl_in,
`endif
   output logic              ready,
   output logic              done,
   output logic [7:0]        dout,
   output logic              ack_out,
   output logic              sda_out,
   output logic              scl_out
);

   eng_state_t state, state_n;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       rd, ack, driven;
   logic       accept, shift, bit_inc, fin;
   logic       phase_end, stretch, hold;
   logic       data_bit, ack_bit;

`ifdef I2C_CLOCK_STRETCH_EN
   assign stretch = ((state == ENG_DATA_HI) || (state == ENG_ACK_HI)) && !scl_in;
`else
   assign stretch = 1'b0;
`endif

   assign hold = (state == ENG_IDLE) || stretch;

   i2c_phase_timer #(.DVSR_W(DVSR_W)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .dvsr      (dbl_clock_divisor),
      .clr       (accept || phase_end),
      .hold      (hold),
      .phase_end (phase_end)
   );

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      shift   = 1'b0;
      bit_inc = 1'b0;
      fin     = 1'b0;
      case (state)
         ENG_IDLE:
            if (start) begin
               accept  = 1'b1;
               state_n = ENG_DATA_LO;
            end
         ENG_DATA_LO:
            if (phase_end) state_n = ENG_DATA_HI;
         ENG_DATA_HI:
            if (phase_end) begin
               shift = 1'b1;
               if (bit_cnt == 3'd7) state_n = ENG_ACK_LO;
               else begin
                  bit_inc = 1'b1;
                  state_n = ENG_DATA_LO;
               end
            end
         ENG_ACK_LO:
            if (phase_end) state_n = ENG_ACK_HI;
         ENG_ACK_HI:
            if (phase_end) begin
               fin     = 1'b1;
               state_n = ENG_IDLE;
            end
         default: state_n = ENG_IDLE;
      endcase
   end

   // Bus drive is a pure function of state; after a byte, IDLE parks SCL low and
   // keeps the ACK-slot SDA level until the next byte starts.
   assign data_bit = rd ? 1'b1 : shreg[7];
   assign ack_bit  = rd ? ack : I2C_NACK;
   assign ready    = (state == ENG_IDLE);

   always_comb begin
      scl_out = 1'b1;
      sda_out = 1'b1;
      case (state)
         ENG_IDLE: begin
            scl_out = !driven;
            sda_out = driven ? ack_bit : 1'b1;
         end
         ENG_DATA_LO: begin
            scl_out = 1'b0;
            sda_out = data_bit;
         end
         ENG_DATA_HI: sda_out = data_bit;
         ENG_ACK_LO: begin
            scl_out = 1'b0;
            sda_out = ack_bit;
         end
         ENG_ACK_HI: sda_out = ack_bit;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ENG_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         rd      <= 1'b0;
         ack     <= I2C_NACK;
         driven  <= 1'b0;
         done    <= 1'b0;
         dout    <= 8'h00;
         ack_out <= 1'b1;
      end else begin
         state <= state_n;
         done  <= fin;
         if (accept) begin
            rd      <= cmd_read;
            ack     <= ack_in;
            shreg   <= din;
            bit_cnt <= '0;
            driven  <= 1'b1;
         end
         if (shift)   shreg   <= {shreg[6:0], rd & sda_in};
         if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
         if (fin) begin
            ack_out <= sda_in;
            if (rd) dout <= shreg;
         end
      end
   end

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Directed bench for i2c_byte_engine with a slave model and an expected-result scoreboard.
module tb_i2c_byte_engine;
   import i2c_byte_engine_pkg::*;

   typedef struct {
      logic [7:0] dout;
      logic       ack;
      logic [8:0] bits;
      int         cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] dvsr;
   logic        start, cmd_read, ack_in, sda_in, scl_in;
   logic [7:0]  din;
   logic        ready, done, ack_out, sda_out, scl_out;
   logic [7:0]  dout;

   int   nerr = 0;
   int   nchk = 0;
   int   cyc  = 0;
   logic [7:0] mdout;
   exp_t sb[$];

   i2c_byte_engine #(.DVSR_W(16)) dut (
      .clk               (clk),
      .reset             (reset),
      .dbl_clock_divisor (dvsr),
      .start             (start),
      .cmd_read          (cmd_read),
      .din               (din),
      .ack_in            (ack_in),
      .sda_in            (sda_in),
`ifdef I2C_CLOCK_STRETCH_EN
      .scl_in            (scl_in),
`endif
      .ready             (ready),
      .done              (done),
      .dout              (dout),
      .ack_out           (ack_out),
      .sda_out           (sda_out),
      .scl_out           (scl_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one byte from the caller's current point (before the accepting edge) up to
   // the negedge of the done cycle; returns the absolute cycle counter at done.
   task automatic xfer(input string tag, input logic rdb, input logic [7:0] d,
                       input logic ackin, input logic [7:0] rdata, input logic sack,
                       input int busy_at, input int stretch_n, input int exp_cyc,
                       output int abs_cyc);
      exp_t e, got;
      int n, nb, held, bad;
      logic [8:0] bits;
      logic pscl, psda;
      e.dout = rdb ? rdata : mdout;
      e.ack  = sack;
      e.bits = rdb ? {8'hFF, ackin} : {d, 1'b1};
      e.cyc  = exp_cyc;
      sb.push_back(e);
      if (rdb) mdout = rdata;
      start = 1'b1; cmd_read = rdb; din = d; ack_in = ackin;
      @(posedge clk); #1 start = 1'b0;
      nb = 0; held = 0; bad = 0; bits = '0; pscl = 1'b0; psda = sda_out;
      for (n = 1; n <= 400; n++) begin
         @(negedge clk);
         start = (n == busy_at);
         if (scl_out && !pscl && nb < 9) begin
            bits[8-nb] = sda_out;
            nb++;
         end
         if (scl_out && pscl && sda_out !== psda) bad++;
         if (!scl_out) sda_in = (nb < 8) ? rdata[7-nb] : sack;
         if (stretch_n > 0) begin
            if (scl_out && held < stretch_n) begin
               scl_in = 1'b0;
               held++;
            end else scl_in = 1'b1;
         end
         pscl = scl_out; psda = sda_out;
         if (done === 1'b1) break;
      end
      start = 1'b0;
      abs_cyc = cyc;
      got = sb.pop_front();
      chk({tag, " done cycle"}, (n > 400) ? 0 : n, got.cyc);
      chk({tag, " dout"}, dout, got.dout);
      chk({tag, " ack_out"}, ack_out, got.ack);
      chk({tag, " bus bits"}, bits, got.bits);
      chk({tag, " sda stable while scl high"}, bad, 0);
      chk({tag, " ready at done"}, ready, 1);
      chk({tag, " scl held low"}, scl_out, 0);
   endtask

   initial begin
      int t1, t2, extra;
      reset = 1'b1; dvsr = 16'd3; start = 1'b0; cmd_read = 1'b0; din = 8'h00;
      ack_in = 1'b1; sda_in = 1'b1; scl_in = 1'b1; mdout = 8'h00;
      #1;
      chk("rst ready", ready, 1);
      chk("rst done", done, 0);
      chk("rst dout", dout, 8'h00);
      chk("rst ack_out", ack_out, 1);
      chk("rst sda", sda_out, 1);
      chk("rst scl", scl_out, 1);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Write A5 with slave ACK, then reads with NACK and ACK at two divisors.
      xfer("wr_a5", 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 0, 0, 73, t1);
      @(negedge clk);
      xfer("rd_3c", 1'b1, 8'h00, 1'b1, 8'h3C, 1'b1, 0, 0, 73, t1);
      dvsr = 16'd1;
      @(negedge clk);
      xfer("rd_c3", 1'b1, 8'h5A, 1'b0, 8'hC3, 1'b0, 0, 0, 37, t1);
      @(negedge clk);
      xfer("wr_ff", 1'b0, 8'hFF, 1'b1, 8'h00, 1'b1, 0, 0, 37, t1);

      // D=0: ignored start while busy, then a back-to-back byte from the done cycle.
      dvsr = 16'd0;
      @(negedge clk);
      xfer("busy", 1'b0, 8'h81, 1'b1, 8'h00, 1'b0, 5, 0, 19, t1);
      xfer("b2b", 1'b1, 8'h00, 1'b1, 8'h6E, 1'b1, 0, 0, 19, t2);
      chk("b2b done spacing", t2 - t1, 19);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      chk("no queued start", extra, 0);

      // Reset asserted in DATA_HI of bit 4 (cycles 37..40 at D=3).
      dvsr = 16'd3;
      start = 1'b1; cmd_read = 1'b0; din = 8'h96;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 1; i < 38; i++) @(negedge clk);
      chk("mid scl high", scl_out, 1);
      reset = 1'b1;
      #1;
      mdout = 8'h00;
      chk("mid rst sda", sda_out, 1);
      chk("mid rst scl", scl_out, 1);
      chk("mid rst ready", ready, 1);
      chk("mid rst done", done, 0);
      chk("mid rst dout", dout, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      extra = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      chk("mid rst no done", extra, 0);

`ifdef I2C_CLOCK_STRETCH_EN
      xfer("stretch", 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 0, 10, 83, t1);
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
